// File: rtl/blu_pkg.sv
// Shared opcodes and stage bundles for the bitwise logic unit.
// Imported by blu_logic_core, bitwise_logic_unit and the bench.
package blu_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_XNOR  = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef struct packed {
    logic [2:0] op;
    logic       acc_mode;
  } s1_ctrl_t;

  function automatic string op_name(input logic [2:0] op);
    case (op)
      OP_AND:   return "AND";
      OP_OR:    return "OR";
      OP_XOR:   return "XOR";
      OP_XNOR:  return "XNOR";
      OP_NAND:  return "NAND";
      OP_NOR:   return "NOR";
      OP_NOTA:  return "NOTA";
      default:  return "PASSB";
    endcase
  endfunction

endpackage

// File: rtl/blu_logic_core.sv
// Combinational bitwise operator: f = op(op_a, b).
// Shared by stage 2 of bitwise_logic_unit; testable on its own.
module blu_logic_core
  import blu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    unique case (op)
      OP_AND:   f = op_a & b;
      OP_OR:    f = op_a | b;
      OP_XOR:   f = op_a ^ b;
      OP_XNOR:  f = ~(op_a ^ b);
      OP_NAND:  f = ~(op_a & b);
      OP_NOR:   f = ~(op_a | b);
      OP_NOTA:  f = ~op_a;
      OP_PASSB: f = b;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage valid/ready bitwise logic unit with accumulator.
// BITWISE_LOGIC_UNIT_REDUCE_EN adds registered red_and/red_or/red_xor.
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic [WIDTH-1:0] acc
`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

  logic             s1_valid_q, s1_valid_d;
  s1_ctrl_t         s1_ctrl_q, s1_ctrl_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] f;

  assign advance  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;
  assign op_a     = s1_ctrl_q.acc_mode ? acc_q : s1_a_q;

  blu_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op  (s1_ctrl_q.op),
    .op_a(op_a),
    .b   (s1_b_q),
    .f   (f)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d         = 1'b1;
      s1_ctrl_d.op       = op;
      s1_ctrl_d.acc_mode = acc_mode;
      s1_a_d             = a;
      s1_b_d             = b;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = 1'b1;
      res_d       = f;
      zero_d      = (f == '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A chained result beats a simultaneous clear.
    if (advance && s1_ctrl_q.acc_mode) begin
      acc_d = f;
    end else if (acc_clr) begin
      acc_d = ACC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      acc_q       <= ACC_INIT;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign zero      = zero_q;
  assign acc       = acc_q;

`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
  logic red_and_q, red_and_d;
  logic red_or_q,  red_or_d;
  logic red_xor_q, red_xor_d;

  always_comb begin
    red_and_d = red_and_q;
    red_or_d  = red_or_q;
    red_xor_d = red_xor_q;
    if (advance) begin
      red_and_d = &f;
      red_or_d  = |f;
      red_xor_d = ^f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_and_q <= 1'b0;
      red_or_q  <= 1'b0;
      red_xor_q <= 1'b0;
    end else begin
      red_and_q <= red_and_d;
      red_or_q  <= red_or_d;
      red_xor_q <= red_xor_d;
    end
  end

  assign red_and = red_and_q;
  assign red_or  = red_or_q;
  assign red_xor = red_xor_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (WIDTH=3, ACC_INIT=111).
// Directed scenarios plus a randomized scoreboard run.
module tb_bitwise_logic_unit;
  import blu_pkg::*;

  localparam int          W    = 3;
  localparam logic [W-1:0] INIT = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         acc_mode;
  logic         acc_clr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         zero;
  logic [W-1:0] acc;
`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
  logic         red_and;
  logic         red_or;
  logic         red_xor;
`endif

  always #5 clk = ~clk;

  bitwise_logic_unit #(
    .WIDTH   (W),
    .ACC_INIT(INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .acc_mode (acc_mode),
    .acc_clr  (acc_clr),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .zero     (zero),
    .acc      (acc)
`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
    ,
    .red_and  (red_and),
    .red_or   (red_or),
    .red_xor  (red_xor)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] ones;
    ones = '1;
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ones - (x ^ y);
      3'd4:    return ones - (x & y);
      3'd5:    return ones - (x | y);
      3'd6:    return ones - x;
      default: return y;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic v,
                     input logic [2:0] o, input logic m,
                     input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic ordy, input logic clr);
    @(negedge clk);
    rst = r; in_valid = v; op = o; acc_mode = m;
    a = aa; b = bb; out_ready = ordy; acc_clr = clr;
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  // Scoreboard for the random run.
  logic [W-1:0] sb_q[$];
  logic [2:0]   sb_op_q[$];
  logic [W-1:0] m_acc;
  logic         prev_stall;
  logic [W-1:0] prev_res;

  task automatic observe();
    logic [W-1:0] e, opa;
    logic [2:0]   eo;
    if (prev_stall) begin
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold res", 32'(res), 32'(prev_res));
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious output", 32'd1, 32'd0);
      end else begin
        e  = sb_q.pop_front();
        eo = sb_op_q.pop_front();
        check($sformatf("rnd res %s", op_name(eo)), 32'(res), 32'(e));
        check("rnd zero", 32'(zero), 32'(e == 0));
`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
        check("rnd red_and", 32'(red_and), 32'(e == INIT));
        check("rnd red_or", 32'(red_or), 32'(e != 0));
        check("rnd red_xor", 32'(red_xor), 32'(e[0] + e[1] + e[2]) & 32'd1);
`endif
      end
    end
    if (in_valid && in_ready) begin
      opa = acc_mode ? m_acc : a;
      e   = ref_f(op, opa, b);
      if (acc_mode) m_acc = e;
      sb_q.push_back(e);
      sb_op_q.push_back(op);
    end
    prev_stall = out_valid && !out_ready;
    prev_res   = res;
  endtask

  logic [W-1:0] exp8[8];
  int k, n_in, n_out;

  initial begin
    exp8 = '{3'b010, 3'b111, 3'b101, 3'b010,
             3'b101, 3'b000, 3'b001, 3'b011};

    // Reset state
    cyc(1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst res", 32'(res), 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    check("rst acc", 32'(acc), 32'(INIT));
    check("rst in_ready", 32'(in_ready), 32'd1);

    // XNOR, two-cycle latency
    cyc(1'b0, 1'b1, OP_XNOR, 1'b0, 3'b001, 3'b111, 1'b1, 1'b0);
    check("t1 in_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    check("t1 early valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    check("t1 out_valid", 32'(out_valid), 32'd1);
    check("t1 res", 32'(res), 32'd1);
    check("t1 zero", 32'(zero), 32'd0);
    idle(1'b1);
    check("t1 valid drop", 32'(out_valid), 32'd0);

    // All ops back-to-back
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) cyc(1'b0, 1'b1, 3'(i), 1'b0, 3'b110, 3'b011, 1'b1, 1'b0);
      else       idle(1'b1);
      if (i < 8) check("t2 in_ready", 32'(in_ready), 32'd1);
      check($sformatf("t2 valid c%0d", i), 32'(out_valid),
            32'(i >= 2 && i < 10));
      if (out_valid) begin
        if (k < 8) begin
          check($sformatf("t2 res %s", op_name(3'(k))), 32'(res), 32'(exp8[k]));
          check("t2 zero", 32'(zero), 32'(k == 5));
        end
        k++;
      end
    end
    check("t2 count", 32'(k), 32'd8);

    // Backpressure
    n_in = 0; n_out = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, n_in < 4, 3'(n_in), 1'b0, 3'b110, 3'b011, i >= 4, 1'b0);
      if (i == 2 || i == 3) begin
        check("t3 in_ready", 32'(in_ready), 32'd0);
        check("t3 accepted", 32'(n_in), 32'd2);
        check("t3 held valid", 32'(out_valid), 32'd1);
        check("t3 held res", 32'(res), 32'(exp8[0]));
      end
      if (out_valid && out_ready) begin
        check("t3 res order", 32'(res), 32'(exp8[n_out]));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
    end
    check("t3 out count", 32'(n_out), 32'd4);

    // Accumulate chain from 111
    cyc(1'b0, 1'b1, OP_XOR, 1'b1, '0, 3'b001, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, OP_XOR, 1'b1, '0, 3'b010, 1'b1, 1'b0);
    idle(1'b1);
    check("t4 res0", 32'(res), 32'(3'b110));
    idle(1'b1);
    check("t4 res1", 32'(res), 32'(3'b100));
    check("t4 acc", 32'(acc), 32'(3'b100));
    idle(1'b1);

    // Clear colliding with an accumulating advance
    cyc(1'b0, 1'b1, OP_XOR, 1'b1, '0, 3'b001, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    check("clr collide res", 32'(res), 32'(3'b101));
    check("clr collide acc", 32'(acc), 32'(3'b101));
    cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    check("clr alone acc", 32'(acc), 32'(INIT));

    // Reset with two in flight
    cyc(1'b0, 1'b1, OP_XOR, 1'b1, '0, 3'b001, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, OP_XOR, 1'b1, '0, 3'b011, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    check("t5 out_valid", 32'(out_valid), 32'd0);
    check("t5 acc", 32'(acc), 32'(INIT));
    check("t5 in_ready", 32'(in_ready), 32'd1);
    check("t5 res", 32'(res), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("t5 no stale", 32'(out_valid), 32'd0);
    end

`ifdef BITWISE_LOGIC_UNIT_REDUCE_EN
    cyc(1'b0, 1'b1, OP_AND, 1'b0, 3'b111, 3'b101, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t6 res", 32'(res), 32'(3'b101));
    check("t6 red_and", 32'(red_and), 32'd0);
    check("t6 red_or", 32'(red_or), 32'd1);
    check("t6 red_xor", 32'(red_xor), 32'd0);
`endif

    // Randomized run against the scoreboard
    cyc(1'b1, 1'b0, 3'd0, 1'b0, '0, '0, 1'b1, 1'b0);
    m_acc = INIT;
    prev_stall = 1'b0;
    prev_res = '0;
    idle(1'b1);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, $urandom_range(0, 3) != 0, 3'($urandom),
          $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom),
          $urandom_range(0, 3) != 0, 1'b0);
      observe();
    end
    for (int g = 0; g < 40 && sb_q.size() != 0; g++) begin
      idle(1'b1);
      observe();
    end
    check("drain empty", 32'(sb_q.size()), 32'd0);
    check("rnd final acc", 32'(acc), 32'(m_acc));
    idle(1'b1);
    check("rnd idle valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
Parametrised, pipelined bitwise logic unit. It applies one of eight bitwise operations to two WIDTH-bit operands.
- Two-stage registered datapath with valid/ready handshake on both sides.
- Optional accumulate mode chains results back as operand A.
- Used as the generic logic slice in datapath experiments and as a reusable operator block for later ALU work.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
ACC_INIT, 0, accumulator value loaded on reset and on acc_clr

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream transaction valid
in_ready  output  1  block can accept a transaction this cycle
op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 PASS B
acc_mode  input  1  1: use accumulator instead of a as operand A
acc_clr  input  1  load ACC_INIT into accumulator (independent of handshake)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
res  output  WIDTH  registered result
zero  output  1  res == 0, registered with res
acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (rst=1 at a clock edge) sets the following; rst overrides every other input, including mid-pipeline transactions, which are dropped:
  - out_valid=0, res=0, zero=1, acc=ACC_INIT.
  - Internal s1_valid=0.
  - in_ready=1 from the first cycle after reset.
- Stage 1 (capture):
  - On in_valid && in_ready, register op, acc_mode, a, b.
  - Set s1_valid=1.
- Stage 2 (compute):
  - s1 advances when s1_valid && (!out_valid || out_ready).
  - On advance: opA = s1_acc_mode ? acc : s1_a.
  - res <= f(op, opA, s1_b); zero <= (f==0); out_valid <= 1.
  - If s1_acc_mode, also acc <= f. Back-to-back accumulate ops therefore chain with no bubble.
- Output: on out_valid && out_ready with no new advance, out_valid <= 0. Holding out_ready=0 keeps res, zero and out_valid stable.
- in_ready = !s1_valid || s1 advancing this cycle (combinational). Full throughput is one transaction per cycle.
- Latency: 2 cycles from input handshake to out_valid with no stall.
- Operations are purely bitwise, all WIDTH bits. NOT A ignores b; PASS B ignores opA.
- acc_clr collisions:
  - If acc_clr coincides with an accumulating advance, the advance result wins for acc and res still reflects pre-clear acc.
  - acc_clr alone loads ACC_INIT.
- Order is strictly in-order. There is no reordering or dropping except on reset.

Optional Feature:
Macro BITWISE_LOGIC_UNIT_REDUCE_EN.
- Defined: adds output ports red_and, red_or, red_xor (1 bit each). They are the reduction of f, registered alongside res under the same valid/stall rules. On reset: red_and=0, red_or=0, red_xor=0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package blu_pkg:
  - Opcode localparams OP_AND..OP_PASSB (3-bit).
  - Op-name function for bench printing.
- Sub-module blu_logic_core: purely combinational (op, opA, b) -> f, WIDTH-parametrised. It is instantiated once in stage 2 and unit-testable alone.

Test Plan:
1. WIDTH=3: a=001, b=111, op=XNOR, out_ready=1 -> res=001, zero=0, out_valid exactly 2 cycles after handshake.
2. Stream all 8 ops with a=110, b=011 back-to-back, out_ready=1 -> results 010, 111, 101, 010, 101, 000, 001, 011 in order, one per cycle; zero=1 only for NOR.
3. Backpressure: out_ready=0 for 4 cycles during a 4-op stream -> in_ready drops after 2 accepted, res held stable, no loss or duplication after release.
4. Accumulate, WIDTH=3, ACC_INIT=111: XOR b=001, then XOR b=010 back-to-back with acc_mode=1 -> res 110 then 100, acc=100.
5. Assert rst mid-stream with 2 transactions in flight -> next cycle out_valid=0, acc=ACC_INIT, in_ready=1; no stale output afterwards.
6. With BITWISE_LOGIC_UNIT_REDUCE_EN: AND a=111, b=101 -> res=101, red_and=0, red_or=1, red_xor=0.
